// File: rtl/pipe_pkg.sv
// Shared definitions for the 4-stage 8-bit pipeline: datapath widths and ALU opcodes.
package pipe_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

endpackage : pipe_pkg

// File: rtl/alu8.sv
// Combinational ALU shared by the EX stage and the future branch unit.
// c is the carry for ADD, the borrow for SUB, and always 0 for AND/OR.
module alu8
    import pipe_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  alu_op_e      op,
    output logic [W-1:0] res,
    output logic         c
);

    logic [W:0] sum;

    // Result and carry/borrow for the selected operation.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        sum = '0;
        res = '0;
        c   = 1'b0;
        case (op)
            ALU_ADD: begin
                sum = {1'b0, op_a} + {1'b0, op_b};
                res = sum[W-1:0];
                c   = sum[W];
            end
            ALU_SUB: begin
                sum = {1'b0, op_a} - {1'b0, op_b};
                res = sum[W-1:0];
                c   = sum[W];
            end
            ALU_AND: res = op_a & op_b;
            ALU_OR:  res = op_a | op_b;
            default: res = '0;
        endcase
    end

endmodule : alu8

// File: rtl/ex_wb_stage.sv
// EX/WB stage: forwards the previous result into operand A, runs the ALU, and
// registers the write-back port, output port, status flags and retired counter.
// The register file must be write-before-read to cover dependencies two or more
// instructions back; only the immediately preceding result is forwarded here.
module ex_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_idex,
    input  logic [1:0]        alu_ctrl_idex,
    input  logic [DATA_W-1:0] data1_idex,
    input  logic [DATA_W-1:0] data2_idex,
    input  logic [ADDR_W-1:0] rd_idex,
    input  logic              output_sel_idex,
    input  logic [ADDR_W-1:0] rs_idex,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] out_port,
    output logic              flag_z,
    output logic              flag_c,
    output logic [CNT_W-1:0]  retired
);

    logic              wb_en_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] out_port_q;
    logic              flag_z_q;
    logic              flag_c_q;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              retire;

    // Operand A comes from the in-flight write-back when it targets rs (any address, r0 included).
    always_comb begin
        op_a = data1_idex;
        if (wb_en_q && (wb_addr_q == rs_idex)) begin
            op_a = wb_data_q;
        end
    end

    alu8 #(
        .W (DATA_W)
    ) u_alu (
        .op_a (op_a),
        .op_b (data2_idex),
        .op   (alu_op_e'(alu_ctrl_idex)),
        .res  (alu_res),
        .c    (alu_c)
    );

    // Non-bubble instructions retire; the counter saturates instead of wrapping.
    always_comb begin
        retire    = reg_write_idex | output_sel_idex;
        retired_d = retired_q;
        if (retire && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // Pipeline, output-port, flag and counter registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (!reset) begin
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            out_port_q <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            wb_en_q   <= reg_write_idex;
            wb_addr_q <= rd_idex;
            wb_data_q <= alu_res;
            if (output_sel_idex) begin
                out_port_q <= alu_res;
            end
            if (retire) begin
                flag_z_q <= (alu_res == '0);
                flag_c_q <= alu_c;
            end
            retired_q <= retired_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign out_port = out_port_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign retired  = retired_q;

endmodule : ex_wb_stage
